rng_arbiter: RTL
================

# rng_arbiter

Shares the single free-running LFSR random source between up to NUM_REQ game-logic clients (LED delay timer, target selector, etc.) so that no two clients ever receive the same or adjacent LFSR states. Each client raises a level request and receives one registered random word with a one-cycle valid pulse. Grants are round-robin and spaced by a fixed cool-down so the LFSR advances STRIDE steps between draws. Sits between the rng instance and its consumers; the LFSR itself is external.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 11, width of random word
- STRIDE, 4, minimum clock edges between consecutive grants (>=1)
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rand_in  in  WIDTH  current LFSR output (rng random_value), sampled on grant edge
- req  in  NUM_REQ  level request per client; held until that client's valid seen
- valid  out  NUM_REQ  one-hot, one-cycle grant pulse; rand_out is meaningful in that cycle
- rand_out  out  WIDTH  random word for the granted client; held until next grant
- grant_id  out  $clog2(NUM_REQ)  index of most recent grantee; held until next grant
- busy  out  1  high while in COOL (no grant possible on the next edge unless cnt==0)

## Operation
- States: IDLE, COOL. Down-counter cnt, width $clog2(STRIDE+1). Round-robin pointer ptr (0..NUM_REQ-1).
- Grant edge: an edge where (state==IDLE or (state==COOL and cnt==0)) and effective request vector nonzero.
- Effective request: req masked by valid (a client whose valid is high this cycle is excluded).
- Winner: first set bit of effective request searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
- On grant edge: rand_out <= rand_in; valid <= one-hot(winner); grant_id <= winner; ptr <= (winner+1) mod NUM_REQ; cnt <= STRIDE-1; state <= COOL.
- COOL, cnt>0: cnt decrements each edge; no grant; valid <= 0.
- COOL, cnt==0, no effective request: state <= IDLE; valid <= 0.
- IDLE, no request: stay; valid <= 0.
- valid never high for two consecutive cycles unless STRIDE==1 (then back-to-back grants allowed, to different or same client per masking).
- Request dropped before grant: simply not served; no pending memory.
- Client keeping req high in the cycle after its valid: treated as a new request at lowest round-robin priority.
- busy = (state==COOL) and (cnt!=0).

## Timing
- Reset (rst_n low, asynchronous, any time): state IDLE, cnt 0, ptr 0, valid 0, rand_out 0, grant_id 0, busy 0. Reset mid-COOL discards cool-down; first grant possible on first edge after rst_n deasserts.
- Latency: req rising before edge t while IDLE -> valid and rand_out visible in cycle after edge t (one cycle).
- rand_out equals rand_in as sampled at the grant edge, not a later value.
- Grant spacing: consecutive grant edges exactly STRIDE edges apart when requests are continuous.
- Simultaneous requests: served one per grant edge in round-robin order from ptr.
- ptr wrap: after granting NUM_REQ-1, ptr = 0.

## Test plan
- Reset: drive rst_n low mid-COOL with req=4'b1111 -> all outputs 0 immediately; after release, first grant to client 0 one edge later.
- Single client: NUM_REQ=4, STRIDE=4, rand_in = free-running edge counter; req[2] high at cycle 10 -> valid=4'b0100 in cycle 11, rand_out=10, grant_id=2; req[2] dropped -> no further valid.
- Fairness: req=4'b1111 held from cycle 0 -> grants to 0,1,2,3,0 on edges 0,4,8,12,16; rand_out 0,4,8,12,16; busy high 3 cycles after each grant.
- Pointer wrap/skip: after grant to 3, req=4'b0101 -> next grant 0 then 2; after grant to 1, req=4'b0011 -> grant 0 before 1.
- Held request: req[1] stays high through its valid, others idle, STRIDE=1 -> valid[1] in alternating cycles only (masked cycle), rand_out values differ by 2.
- Dropped request: req[3] high only during busy cycles -> never granted, valid stays 0.

Source files
------------

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sharing of one free-running LFSR word
// between several clients, with a fixed cool-down between draws.
module rng_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 11,
    parameter int STRIDE  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           rand_in,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         valid,
    output logic [WIDTH-1:0]           rand_out,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(STRIDE + 1);

    typedef enum logic {
        S_IDLE,
        S_COOL
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [IDW-1:0]     r_ptr;
    logic [NUM_REQ-1:0] r_valid;
    logic [WIDTH-1:0]   r_rand;
    logic [IDW-1:0]     r_gid;

    logic [NUM_REQ-1:0] w_eff;
    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_nptr;
    logic               w_can;
    logic               w_grant;

    // A client just served this cycle must not win again on this edge
    assign w_eff   = req & ~r_valid;
    assign w_can   = (r_state == S_IDLE) || (r_cnt == '0);
    assign w_grant = w_can && w_found;
    assign w_nptr  = (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

    // Round-robin search starting at the pointer, wrapping around
    always_comb begin
        int k;
        k       = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(r_ptr) + i) % NUM_REQ;
            if (!w_found && w_eff[IDW'(k)]) begin
                w_found = 1'b1;
                w_win   = IDW'(k);
            end
        end
    end

    // Grant / cool-down state machine with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_valid <= '0;
            r_rand  <= '0;
            r_gid   <= '0;
        end else begin
            r_valid <= '0;
            if (w_grant) begin
                r_rand  <= rand_in;
                r_valid <= NUM_REQ'(1) << w_win;
                r_gid   <= w_win;
                r_ptr   <= w_nptr;
                r_cnt   <= CW'(STRIDE - 1);
                r_state <= S_COOL;
            end else if (r_state == S_COOL) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end else begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign valid    = r_valid;
    assign rand_out = r_rand;
    assign grant_id = r_gid;
    assign busy     = (r_state == S_COOL) && (r_cnt != '0);

endmodule
